usb_tx_serializer: RTL and testbench
====================================

// Module: usb_tx_serializer
// PURPOSE
//  Transmit-side counterpart of the USB full-speed receive timer/shifter.
//  Takes bytes over a valid/ready handshake and serialises them LSB-first.
//  Generates one bit period every CLKS_PER_BIT clocks, which is 12 Mbps at 96 MHz.
//  Applies bit stuffing and NRZI encoding, drives d_plus/d_minus and appends EOP.
//  Sits between the packet-building TX controller and the bus drivers.
// PARAMETERS
//  CLKS_PER_BIT  8  system clocks per bus bit period (96 MHz / 12 Mbps)
//  STUFF_LEN     6  consecutive encoded 1s after which a stuff 0 is inserted
// PORTS
//  clk            in   1  system clock, 96 MHz; all state changes on rising edge
//  rst            in   1  asynchronous, active-high reset
//  tx_data        in   8  byte to send, LSB first; upstream supplies SYNC/PID/CRC bytes
//  tx_data_valid  in   1  tx_data/tx_last valid
//  tx_last        in   1  qualifies tx_data: this byte is the final byte of the packet
//  tx_data_ready  out  1  serializer accepts a byte this cycle (valid && ready)
//  byte_sent      out  1  1-cycle pulse when final data bit of a byte completes
//  tx_done        out  1  1-cycle pulse on return to IDLE after EOP
//  tx_error       out  1  1-cycle pulse on underrun (no byte at a mid-packet boundary)
//  transmitting   out  1  high in every state except IDLE
//  d_plus         out  1  bus D+ (registered)
//  d_minus        out  1  bus D- (registered)
// BEHAVIOUR
//  - Reset, asynchronous, any state: IDLE; line J (d_plus=1, d_minus=0); all pulses 0;
//    transmitting=0; counters and ones count cleared. tx_data_ready=1 in IDLE.
//  - Reset mid-packet: line snaps to J at once, no EOP, no tx_done.
//  - States: IDLE, SHIFT, STUFF, EOP_SE0, EOP_J.
//  - Bit timer: counts 0..CLKS_PER_BIT-1 and wraps.
//    strobe = (count == CLKS_PER_BIT-1); a bit period ends on its strobe cycle.
//    Timer is held at 0 in IDLE.
//  - Line value for a period is registered on the cycle after the previous strobe.
//    From IDLE, the line value is registered on the cycle after acceptance.
//  - IDLE: if the byte is accepted at cycle T, go to SHIFT. Bit0 is on the line
//    from T+1 for CLKS_PER_BIT cycles.
//  - NRZI: data 0 toggles the line (J<->K, K = d_plus 0/d_minus 1); data 1 holds it.
//  - Stuffing: ones counter increments on each data 1 and clears on a data 0.
//    When it reaches STUFF_LEN, the next period is STUFF (line toggles) and the
//    counter clears. Stuffing applies across byte boundaries and before EOP.
//    Ones counter clears on packet start.
//  - Byte boundary = strobe ending bit7, or ending the STUFF period that follows bit7.
//    * byte_sent pulses on the strobe ending bit7, even if a stuff bit follows.
//    * not last: tx_data_ready=1 on the boundary cycle only. If valid, the next
//      byte's bit0 follows seamlessly.
//    * not last and !tx_data_valid on the boundary cycle: tx_error pulses, go to EOP.
//    * last: tx_data_ready stays 0, go to EOP_SE0.
//  - tx_data_ready is 0 in all non-boundary cycles of SHIFT/STUFF/EOP.
//  - EOP_SE0: d_plus=0, d_minus=0 for 2 bit periods. EOP_J: J for 1 bit period.
//    Then IDLE. tx_done is high in the first IDLE cycle.
//  - tx_data, tx_last and tx_data_valid are ignored except in accept cycles.
//  - Simultaneous underrun and pending stuff bit: the stuff bit is sent first,
//    then the boundary check is made.
// TESTING
//  - 0x80 with tx_last accepted at T: d_plus per period 0,1,0,1,0,1,0,0.
//    Then SE0 for 16 cycles, then J for 8 cycles. byte_sent at T+64, tx_done at T+89.
//  - 0xFF,0xFF (second byte last): 18 bit periods.
//    Stuff toggles follow the 6th and 12th data bits; line otherwise holds.
//  - 0x7E then 0x3F back-to-back: tx_data_ready is high for exactly 1 cycle at the
//    boundary. Bit0 of 0x3F starts on the next cycle with no gap.
//  - Underrun: 0x80 not last, valid held low at the boundary: tx_error pulses,
//    SE0 for 16 cycles, J for 8 cycles, then tx_done.
//  - rst asserted during bit3 of a byte: d_plus=1/d_minus=0 and transmitting=0 at once.
//    No tx_done. The next byte accepted after release transmits normally.
//  - Six data 1s then tx_last at byte end (0xFC last after 0x00): stuff bit precedes
//    SE0. Total periods = 16 + 1, then EOP.

Source files
------------

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: USB full-speed byte serialiser with bit stuffing, NRZI encoding and EOP generation
module usb_tx_serializer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ready,
  output logic       byte_sent,
  output logic       tx_done,
  output logic       tx_error,
  output logic       transmitting,
  output logic       d_plus,
  output logic       d_minus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LEN + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, STUFF, EOP_SE0, EOP_J} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0]    sh, sh_n;
  logic [2:0]    idx, idx_n;
  logic [OW-1:0] ones, ones_n, ones_inc;
  logic          last_r, last_n, half, half_n, dp_n, dm_n, done_n;
  logic          strobe, boundary, accept;
  assign strobe       = cnt == CW'(CLKS_PER_BIT - 1);
  assign ones_inc     = sh[0] ? ones + 1'b1 : '0;
  assign transmitting = state != IDLE;
  // State, bit timer, shifter and registered line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      idx     <= '0;
      ones    <= '0;
      last_r  <= 1'b0;
      half    <= 1'b0;
      d_plus  <= 1'b1;
      d_minus <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= (state == IDLE || strobe) ? '0 : cnt + 1'b1;
      sh      <= sh_n;
      idx     <= idx_n;
      ones    <= ones_n;
      last_r  <= last_n;
      half    <= half_n;
      d_plus  <= dp_n;
      d_minus <= dm_n;
      tx_done <= done_n;
    end
  end
  // Next state, next line value and handshake/pulse outputs
  always_comb begin
    state_n       = state;
    sh_n          = sh;
    idx_n         = idx;
    ones_n        = ones;
    last_n        = last_r;
    half_n        = half;
    dp_n          = d_plus;
    dm_n          = d_minus;
    done_n        = 1'b0;
    tx_data_ready = 1'b0;
    byte_sent     = 1'b0;
    tx_error      = 1'b0;
    boundary      = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        tx_data_ready = 1'b1;
        accept        = tx_data_valid;
        ones_n        = '0;
      end
      SHIFT: if (strobe) begin
        ones_n    = ones_inc;
        byte_sent = idx == 3'd7;
        if (ones_inc == OW'(STUFF_LEN)) begin
          state_n = STUFF;
          ones_n  = '0;
          dp_n    = ~d_plus;
          dm_n    = ~d_minus;
        end else if (idx != 3'd7) begin
          sh_n  = sh >> 1;
          idx_n = idx + 1'b1;
          dp_n  = sh[1] ? d_plus : ~d_plus;
          dm_n  = sh[1] ? d_minus : ~d_minus;
        end else begin
          boundary = 1'b1;
        end
      end
      STUFF: if (strobe) begin
        if (idx != 3'd7) begin
          state_n = SHIFT;
          sh_n    = sh >> 1;
          idx_n   = idx + 1'b1;
          dp_n    = sh[1] ? d_plus : ~d_plus;
          dm_n    = sh[1] ? d_minus : ~d_minus;
        end else begin
          boundary = 1'b1;
        end
      end
      EOP_SE0: if (strobe) begin
        half_n = ~half;
        if (half) begin
          state_n = EOP_J;
          dp_n    = 1'b1;
          dm_n    = 1'b0;
        end
      end
      EOP_J: if (strobe) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (boundary) begin
      tx_data_ready = !last_r;
      accept        = !last_r && tx_data_valid;
      tx_error      = !last_r && !tx_data_valid;
      if (last_r || !tx_data_valid) begin
        state_n = EOP_SE0;
        half_n  = 1'b0;
        dp_n    = 1'b0;
        dm_n    = 1'b0;
      end
    end
    if (accept) begin
      state_n = SHIFT;
      sh_n    = tx_data;
      idx_n   = '0;
      last_n  = tx_last;
      dp_n    = tx_data[0] ? d_plus : ~d_plus;
      dm_n    = tx_data[0] ? d_minus : ~d_minus;
    end
  end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: table-driven check of line patterns, handshake pulses, EOP timing and reset
module tb_usb_tx_serializer;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_data_valid = 1'b0, tx_last = 1'b0;
  logic       tx_data_ready, byte_sent, tx_done, tx_error, transmitting, d_plus, d_minus;
  int         n_cmp = 0, n_bad = 0;

  usb_tx_serializer dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_last(tx_last),
    .tx_data_ready(tx_data_ready), .byte_sent(byte_sent), .tx_done(tx_done), .tx_error(tx_error),
    .transmitting(transmitting), .d_plus(d_plus), .d_minus(d_minus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        last0;
    logic        two;
    int          np;
    logic [31:0] dp;
    int          bs1;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends b0 (and b1 if two), samples mid-period line values, EOP and pulse timing
  task automatic run_pkt(input vec_t v, input int id);
    int   done_at = -1, bs_at = -1, n_rdy = 0, n_bs = 0, n_te = 0, k, last_c;
    logic acc = 1'b0;
    last_c = 8 * v.np + 26;
    @(negedge clk);
    tx_data = v.b0; tx_last = v.last0; tx_data_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tx_data = v.b1; tx_last = 1'b1; tx_data_valid = v.two;
        chk($sformatf("p%0d_transmitting", id), {31'd0, transmitting}, 32'd1);
      end
      if (acc) begin tx_data_valid = 1'b0; acc = 1'b0; end
      if (tx_data_ready && tx_data_valid) acc = 1'b1;
      if (c <= 8 * v.np + 24 && tx_data_ready) n_rdy++;
      if (byte_sent) begin n_bs++; if (bs_at < 0) bs_at = c; end
      if (tx_error) n_te++;
      if (tx_done && done_at < 0) done_at = c;
      if (c % 8 == 5) begin
        k = (c - 5) / 8;
        if (k < v.np)
          chk($sformatf("p%0d_line%0d", id, k), {30'd0, d_plus, d_minus}, {30'd0, v.dp[k], ~v.dp[k]});
        else if (k < v.np + 2)
          chk($sformatf("p%0d_se0_%0d", id, k - v.np), {30'd0, d_plus, d_minus}, 32'd0);
        else
          chk($sformatf("p%0d_eop_j", id), {30'd0, d_plus, d_minus}, 32'd2);
      end
    end
    tx_data_valid = 1'b0;
    chk($sformatf("p%0d_done_at", id), done_at, 8 * v.np + 25);
    chk($sformatf("p%0d_bs_first", id), bs_at, v.bs1);
    chk($sformatf("p%0d_bs_count", id), n_bs, v.two ? 2 : 1);
    chk($sformatf("p%0d_ready_count", id), n_rdy, v.last0 ? 0 : 1);
    chk($sformatf("p%0d_err_count", id), n_te, (!v.last0 && !v.two) ? 1 : 0);
    chk($sformatf("p%0d_idle", id), {30'd0, transmitting, d_plus}, 32'd1);
  endtask

  initial begin
    int n_done;
    tbl[0] = '{8'h80, 8'h00, 1'b1, 1'b0, 8,  32'h0000_002A, 64};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 18, 32'h0003_E03F, 72};
    tbl[2] = '{8'h7E, 8'h3F, 1'b0, 1'b1, 18, 32'h0002_8080, 72};
    tbl[3] = '{8'h00, 8'hFC, 1'b0, 1'b1, 17, 32'h0000_FEAA, 64};
    tbl[4] = '{8'h80, 8'h00, 1'b0, 1'b0, 8,  32'h0000_002A, 64};
    repeat (3) @(negedge clk);
    chk("rst_outputs", {25'd0, d_plus, d_minus, transmitting, tx_data_ready, byte_sent, tx_done, tx_error},
        {25'd0, 7'b1001000});
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", {25'd0, d_plus, d_minus, transmitting, tx_data_ready, byte_sent, tx_done, tx_error},
        {25'd0, 7'b1001000});
    for (int i = 0; i < 5; i++) begin
      run_pkt(tbl[i], i);
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    tx_data = 8'h55; tx_last = 1'b0; tx_data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data_valid = 1'b0;
    repeat (27) @(negedge clk);
    chk("pre_rst_transmitting", {31'd0, transmitting}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_line", {29'd0, d_plus, d_minus, transmitting}, 32'b100);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_done) n_done++;
    end
    chk("rst_no_done", n_done, 0);
    chk("rst_after_idle", {29'd0, d_plus, d_minus, transmitting}, 32'b100);
    run_pkt(tbl[0], 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
